// File: rtl/blackjack_pkg.sv
// blackjack_pkg: constants and state encodings shared by the card dealer
// and the blackjack game FSM.
// Contents:
//   DECK_SIZE_DEFAULT  default number of cards in one deck
//   RANKS              ranks per suit (A..K)
//   FACE_VALUE         hand value of J, Q and K
//   ACE_VALUE          hand value of an ace (soft-ace logic lives in the game FSM)
//   dealer_state_t     dealer FSM encoding (2 bits)
package blackjack_pkg;

   localparam int         DECK_SIZE_DEFAULT = 52;
   localparam int         RANKS             = 13;
   localparam logic [4:0] FACE_VALUE        = 5'd10;
   localparam logic [4:0] ACE_VALUE         = 5'd1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEARCH  = 2'd1,
      DELIVER = 2'd2
   } dealer_state_t;

endpackage

// File: rtl/card_dealer_lfsr6.sv
// lfsr6: 6-bit Fibonacci LFSR, polynomial x^6 + x^5 + 1 (maximal length 63).
// Ports:
//   Clock    in   system clock
//   reset_n  in   asynchronous active-low reset, loads SEED
//   enable   in   advance one step per cycle when high
//   q        out  current LFSR state
// SEED must be nonzero; from a nonzero state the all-zero state is never
// reached, so no lock-up recovery is needed.
module lfsr6 #(
   parameter logic [5:0] SEED = 6'h2B
) (
   input  logic       Clock,
   input  logic       reset_n,
   input  logic       enable,
   output logic [5:0] q
);

   // Shift toward the MSB; feedback taps are stages 6 and 5.
   always_ff @(posedge Clock or negedge reset_n) begin
      if (!reset_n) begin
         q <= SEED;
      end else if (enable) begin
         q <= {q[4:0], q[5] ^ q[4]};
      end
   end

endmodule

// File: rtl/card_dealer.sv
// card_dealer: deals cards from one shuffled deck to the game FSM, never
// repeating a card until the deck is reshuffled.
// Ports:
//   Clock       in   system clock
//   reset_n     in   asynchronous active-low reset
//   req         in   card request, accepted only while ready=1
//   shuffle     in   return every card to the deck (1-cycle pulse)
//   ready       out  dealer idle, can accept req
//   card_valid  out  1-cycle pulse, card_* valid in this cycle
//   card_value  out  blackjack value (ace=1, J/Q/K=10)
//   card_rank   out  rank 1..13 (A..K)
//   card_index  out  deck slot 0..DECK_SIZE-1
//   cards_left  out  undealt cards remaining
//   deck_empty  out  cards_left == 0
//   deal_err    out  1-cycle pulse when a req is refused on an empty deck
// The free-running LFSR picks a starting slot; SEARCH then walks forward one
// slot per cycle until it finds a card not yet dealt.
module card_dealer
   import blackjack_pkg::*;
#(
   parameter int         DECK_SIZE      = DECK_SIZE_DEFAULT,
   parameter logic [5:0] LFSR_SEED      = 6'h2B,
   parameter bit         AUTO_RESHUFFLE = 1'b1
) (
   input  logic       Clock,
   input  logic       reset_n,
   input  logic       req,
   input  logic       shuffle,
   output logic       ready,
   output logic       card_valid,
   output logic [4:0] card_value,
   output logic [3:0] card_rank,
   output logic [5:0] card_index,
   output logic [5:0] cards_left,
   output logic       deck_empty,
   output logic       deal_err
);

   localparam logic [5:0] FULL_DECK = 6'(DECK_SIZE);
   localparam logic [5:0] LAST_SLOT = 6'(DECK_SIZE - 1);

   dealer_state_t          state;
   logic [DECK_SIZE-1:0]   dealt;
   logic [5:0]             idx;
   logic [5:0]             lfsr_q;
   logic [5:0]             start_slot;
   logic [3:0]             slot_rank;

   // Fold a raw 0..63 LFSR value into 0..DECK_SIZE-1 by repeated subtraction;
   // four passes cover the smallest deck (13 cards).
   function automatic logic [5:0] fold_slot(input logic [5:0] raw);
      logic [5:0] r;
      r = raw;
      for (int k = 0; k < 4; k++) begin
         if (r >= FULL_DECK) r = r - FULL_DECK;
      end
      return r;
   endfunction

   // Slot-to-rank decode: (slot mod 13) + 1, slot is below 52.
   function automatic logic [3:0] rank_of(input logic [5:0] slot);
      logic [5:0] r;
      r = slot;
      for (int k = 0; k < 3; k++) begin
         if (r >= 6'(RANKS)) r = r - 6'(RANKS);
      end
      return 4'(r + 6'd1);
   endfunction

   // Rank-to-value decode for the 5-bit hand registers.
   function automatic logic [4:0] value_of(input logic [3:0] rank);
      if (rank == 4'd1) return ACE_VALUE;
      else if (rank > 4'd10) return FACE_VALUE;
      else return {1'b0, rank};
   endfunction

   lfsr6 #(
      .SEED(LFSR_SEED)
   ) rng (
      .Clock  (Clock),
      .reset_n(reset_n),
      .enable (1'b1),
      .q      (lfsr_q)
   );

   assign start_slot = fold_slot(lfsr_q);
   assign slot_rank  = rank_of(idx);
   assign deck_empty = (cards_left == 6'd0);

   // Dealer FSM. shuffle has priority in every state: it drops any request
   // in flight and never marks a card found in the same cycle as dealt.
   always_ff @(posedge Clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         dealt      <= '0;
         cards_left <= FULL_DECK;
         idx        <= 6'd0;
         ready      <= 1'b1;
         card_valid <= 1'b0;
         deal_err   <= 1'b0;
         card_value <= 5'd0;
         card_rank  <= 4'd0;
         card_index <= 6'd0;
      end else begin
         card_valid <= 1'b0;
         deal_err   <= 1'b0;
         if (shuffle) begin
            dealt      <= '0;
            cards_left <= FULL_DECK;
            state      <= IDLE;
            ready      <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (req) begin
                     if (cards_left != 6'd0) begin
                        idx   <= start_slot;
                        state <= SEARCH;
                        ready <= 1'b0;
                     end else if (AUTO_RESHUFFLE) begin
                        dealt      <= '0;
                        cards_left <= FULL_DECK;
                        idx        <= start_slot;
                        state      <= SEARCH;
                        ready      <= 1'b0;
                     end else begin
                        deal_err <= 1'b1;
                     end
                  end
               end
               SEARCH: begin
                  if (!dealt[idx]) begin
                     dealt[idx] <= 1'b1;
                     if (cards_left != 6'd0) cards_left <= cards_left - 6'd1;
                     card_index <= idx;
                     card_rank  <= slot_rank;
                     card_value <= value_of(slot_rank);
                     card_valid <= 1'b1;
                     state      <= DELIVER;
                  end else begin
                     idx <= (idx == LAST_SLOT) ? 6'd0 : idx + 6'd1;
                  end
               end
               DELIVER: begin
                  state <= IDLE;
                  ready <= 1'b1;
               end
               default: begin
                  state <= IDLE;
                  ready <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: scoreboard bench for card_dealer. Two instances share
// stimulus: dut_a reshuffles on an empty deck, dut_b refuses. A reference
// model of the deck and LFSR pushes the expected card for each accepted
// request; a monitor pops and compares whenever card_valid is seen.
module tb_card_dealer;

   localparam int DECK = 52;

   typedef struct packed {
      int index;
      int rank;
      int value;
      int issue;
      int lat;
   } card_t;

   logic       Clock = 1'b0;
   logic       reset_n;
   logic       req;
   logic       shuffle;

   logic       ready_a, card_valid_a, deck_empty_a, deal_err_a;
   logic [4:0] card_value_a;
   logic [3:0] card_rank_a;
   logic [5:0] card_index_a, cards_left_a;
   logic       ready_b, card_valid_b, deck_empty_b, deal_err_b;
   logic [4:0] card_value_b;
   logic [3:0] card_rank_b;
   logic [5:0] card_index_b, cards_left_b;

   int checks = 0;
   int failures = 0;
   int cycle = 0;

   logic [5:0] m_lfsr;
   bit         m_dealt [2][DECK];
   int         m_left [2];
   int         err_exp [2];
   int         err_seen [2];
   int         valid_cnt [2];
   card_t      exp_a [$];
   card_t      exp_b [$];
   int         seen_index [DECK];
   int         rank_count [16];
   int         value_sum = 0;

   always #5 Clock = ~Clock;

   always @(posedge Clock) cycle <= cycle + 1;

   card_dealer #(
      .DECK_SIZE(52), .LFSR_SEED(6'h2B), .AUTO_RESHUFFLE(1'b1)
   ) dut_a (
      .Clock(Clock), .reset_n(reset_n), .req(req), .shuffle(shuffle),
      .ready(ready_a), .card_valid(card_valid_a), .card_value(card_value_a),
      .card_rank(card_rank_a), .card_index(card_index_a),
      .cards_left(cards_left_a), .deck_empty(deck_empty_a), .deal_err(deal_err_a)
   );

   card_dealer #(
      .DECK_SIZE(52), .LFSR_SEED(6'h2B), .AUTO_RESHUFFLE(1'b0)
   ) dut_b (
      .Clock(Clock), .reset_n(reset_n), .req(req), .shuffle(shuffle),
      .ready(ready_b), .card_valid(card_valid_b), .card_value(card_value_b),
      .card_rank(card_rank_b), .card_index(card_index_b),
      .cards_left(cards_left_b), .deck_empty(deck_empty_b), .deal_err(deal_err_b)
   );

   // Reference LFSR: x^6 + x^5 + 1, seed 0x2B, steps every cycle.
   always @(posedge Clock or negedge reset_n) begin
      if (!reset_n) m_lfsr <= 6'h2B;
      else m_lfsr <= {m_lfsr[4:0], m_lfsr[5] ^ m_lfsr[4]};
   end

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   function automatic int start_slot(input logic [5:0] l);
      int s;
      s = int'(l);
      while (s >= DECK) s -= DECK;
      return s;
   endfunction

   // Number of slots SEARCH will inspect if dut_a accepts a req now.
   function automatic int search_len(input logic [5:0] l);
      int s, steps;
      if (m_left[0] == 0) return 0;
      s = start_slot(l);
      steps = 1;
      while (m_dealt[0][s]) begin
         s = (s == DECK - 1) ? 0 : s + 1;
         steps++;
      end
      return steps;
   endfunction

   task automatic model_clear(input int d);
      for (int i = 0; i < DECK; i++) m_dealt[d][i] = 1'b0;
      m_left[d] = DECK;
   endtask

   task automatic model_deal(input int d);
      int s, steps;
      card_t c;
      if (m_left[d] == 0) begin
         if (d == 0) begin
            model_clear(0);
         end else begin
            err_exp[d]++;
            return;
         end
      end
      s = start_slot(m_lfsr);
      steps = 1;
      while (m_dealt[d][s]) begin
         s = (s == DECK - 1) ? 0 : s + 1;
         steps++;
      end
      m_dealt[d][s] = 1'b1;
      m_left[d]--;
      c.index = s;
      c.rank  = (s % 13) + 1;
      c.value = (c.rank > 10) ? 10 : c.rank;
      c.issue = cycle;
      c.lat   = steps + 1;
      if (d == 0) exp_a.push_back(c);
      else exp_b.push_back(c);
   endtask

   // Called at a falling edge with both dealers idle: update the model for
   // what the next rising edge will do, drive the inputs, hold one cycle.
   task automatic apply_stimulus(input logic r, input logic s);
      if (s) begin
         model_clear(0);
         model_clear(1);
      end else if (r) begin
         model_deal(0);
         model_deal(1);
      end
      req = r;
      shuffle = s;
      @(negedge Clock);
   endtask

   task automatic wait_both_ready(input string name);
      int n;
      n = 0;
      while (!(ready_a && ready_b) && n < 100) begin
         @(negedge Clock);
         n++;
      end
      check_output(name, int'(ready_a && ready_b), 1);
   endtask

   task automatic deal_one();
      apply_stimulus(1'b1, 1'b0);
      req = 1'b0;
      wait_both_ready("deal ready");
   endtask

   // Scoreboard monitor: pop and compare on every card_valid.
   always @(negedge Clock) begin : monitor
      card_t c;
      if (reset_n) begin
         if (card_valid_a) begin
            valid_cnt[0]++;
            if (exp_a.size() == 0) begin
               check_output("a unexpected card_valid", int'(card_valid_a), 0);
            end else begin
               c = exp_a.pop_front();
               check_output("a card_index", int'(card_index_a), c.index);
               check_output("a card_rank", int'(card_rank_a), c.rank);
               check_output("a card_value", int'(card_value_a), c.value);
               check_output("a latency", cycle - c.issue, c.lat);
            end
            if (int'(card_index_a) < DECK) seen_index[card_index_a]++;
            rank_count[card_rank_a]++;
            value_sum += int'(card_value_a);
         end
         if (card_valid_b) begin
            valid_cnt[1]++;
            if (exp_b.size() == 0) begin
               check_output("b unexpected card_valid", int'(card_valid_b), 0);
            end else begin
               c = exp_b.pop_front();
               check_output("b card_index", int'(card_index_b), c.index);
               check_output("b card_rank", int'(card_rank_b), c.rank);
               check_output("b card_value", int'(card_value_b), c.value);
               check_output("b latency", cycle - c.issue, c.lat);
            end
         end
         if (deal_err_a) err_seen[0]++;
         if (deal_err_b) err_seen[1]++;
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int v0, vb0, e0, left0, n, cnt, got_valid;
      bit b_dropped;
      card_t tmp;

      req = 1'b0;
      shuffle = 1'b0;
      reset_n = 1'b0;
      model_clear(0);
      model_clear(1);
      #12;
      check_output("reset ready", int'(ready_a), 1);
      check_output("reset card_valid", int'(card_valid_a), 0);
      check_output("reset cards_left", int'(cards_left_a), 52);
      check_output("reset deck_empty", int'(deck_empty_a), 0);
      check_output("reset card_index", int'(card_index_a), 0);
      check_output("reset card_rank", int'(card_rank_a), 0);
      check_output("reset card_value", int'(card_value_a), 0);
      check_output("reset deal_err", int'(deal_err_a), 0);
      @(negedge Clock);
      reset_n = 1'b1;
      @(negedge Clock);

      $display("[TB] dealing the first 50 cards");
      for (int i = 0; i < 50; i++) deal_one();

      $display("[TB] stray req pulses while busy");
      n = 0;
      while (search_len(m_lfsr) < 6 && n < 300) begin
         @(negedge Clock);
         n++;
      end
      v0 = valid_cnt[0];
      left0 = int'(cards_left_a);
      apply_stimulus(1'b1, 1'b0);
      req = 1'b0;
      @(negedge Clock);
      for (int p = 0; p < 3; p++) begin
         req = 1'b1;
         @(negedge Clock);
         req = 1'b0;
         @(negedge Clock);
      end
      wait_both_ready("stray ready");
      check_output("stray single card", valid_cnt[0] - v0, 1);
      check_output("stray cards_left", int'(cards_left_a), left0 - 1);

      deal_one();
      check_output("full deal count", valid_cnt[0], 52);
      check_output("full cards_left a", int'(cards_left_a), 0);
      check_output("full deck_empty a", int'(deck_empty_a), 1);
      check_output("full cards_left b", int'(cards_left_b), 0);
      check_output("full deck_empty b", int'(deck_empty_b), 1);
      cnt = 0;
      for (int i = 0; i < DECK; i++) if (seen_index[i] == 1) cnt++;
      check_output("indices dealt once", cnt, 52);
      cnt = 0;
      for (int r = 1; r <= 13; r++) if (rank_count[r] == 4) cnt++;
      check_output("ranks seen four times", cnt, 13);
      check_output("value sum", value_sum, 340);

      $display("[TB] request on an empty deck");
      v0 = valid_cnt[0];
      vb0 = valid_cnt[1];
      e0 = err_seen[1];
      apply_stimulus(1'b1, 1'b0);
      req = 1'b0;
      b_dropped = 1'b0;
      n = 0;
      while (!ready_a && n < 100) begin
         if (!ready_b) b_dropped = 1'b1;
         @(negedge Clock);
         n++;
      end
      check_output("empty a ready", int'(ready_a), 1);
      check_output("empty a reshuffle deal", valid_cnt[0] - v0, 1);
      check_output("empty a cards_left", int'(cards_left_a), 51);
      check_output("empty a no deal_err", err_seen[0], 0);
      check_output("empty b deal_err pulse", err_seen[1] - e0, 1);
      check_output("empty b deal_err model", err_seen[1], err_exp[1]);
      check_output("empty b no card", valid_cnt[1] - vb0, 0);
      check_output("empty b ready held", int'(b_dropped), 0);
      check_output("empty b cards_left", int'(cards_left_b), 0);

      apply_stimulus(1'b0, 1'b1);
      shuffle = 1'b0;
      check_output("shuffle cards_left a", int'(cards_left_a), 52);
      check_output("shuffle cards_left b", int'(cards_left_b), 52);
      check_output("shuffle deck_empty b", int'(deck_empty_b), 0);

      $display("[TB] shuffle aborting a search");
      for (int i = 0; i < 10; i++) deal_one();
      check_output("ten dealt cards_left", int'(cards_left_a), 42);
      v0 = valid_cnt[0];
      apply_stimulus(1'b1, 1'b0);
      req = 1'b0;
      tmp = exp_a.pop_back();
      tmp = exp_b.pop_back();
      apply_stimulus(1'b0, 1'b1);
      shuffle = 1'b0;
      check_output("abort ready", int'(ready_a), 1);
      repeat (4) @(negedge Clock);
      check_output("abort no card", valid_cnt[0] - v0, 0);
      check_output("abort cards_left a", int'(cards_left_a), 52);
      check_output("abort cards_left b", int'(cards_left_b), 52);

      $display("[TB] req and shuffle together");
      v0 = valid_cnt[0];
      e0 = err_seen[1];
      apply_stimulus(1'b1, 1'b1);
      req = 1'b0;
      shuffle = 1'b0;
      repeat (4) @(negedge Clock);
      check_output("both no card", valid_cnt[0] - v0, 0);
      check_output("both cards_left", int'(cards_left_a), 52);
      check_output("both ready", int'(ready_a), 1);
      check_output("both no deal_err", err_seen[1] - e0, 0);

      $display("[TB] reset during DELIVER");
      apply_stimulus(1'b1, 1'b0);
      req = 1'b0;
      n = 0;
      while (!card_valid_a && n < 60) begin
         @(posedge Clock);
         #1;
         n++;
      end
      got_valid = int'(card_valid_a);
      reset_n = 1'b0;
      #1;
      check_output("deliver seen before reset", got_valid, 1);
      check_output("async card_valid", int'(card_valid_a), 0);
      check_output("async ready", int'(ready_a), 1);
      check_output("async cards_left", int'(cards_left_a), 52);
      check_output("async card_index", int'(card_index_a), 0);
      check_output("async card_rank", int'(card_rank_a), 0);
      check_output("async card_value", int'(card_value_a), 0);
      check_output("async deck_empty", int'(deck_empty_a), 0);
      exp_a.delete();
      exp_b.delete();
      model_clear(0);
      model_clear(1);
      @(negedge Clock);
      reset_n = 1'b1;
      @(negedge Clock);
      deal_one();
      check_output("post reset cards_left", int'(cards_left_a), 51);
      check_output("queue a drained", exp_a.size(), 0);
      check_output("queue b drained", exp_b.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
